clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Sequences the push-button front end and the time-setting path of the clock.
- Generates the shared enable strobe that clocks every button debouncer.
- Consumes the debouncers' one-enable-period press pulses (MODE, INC, DEC) and runs the RUN / set-hours / set-minutes / set-seconds state machine.
- Owns the edit registers and commits them to the timekeeper with a single load strobe.

Parameters:
- TICK_DIV, 200000, clocks per debouncer enable strobe (2 ms at 100 MHz); must be >= 2.
- AUTO_EXIT_TICKS, 5000, enable ticks with no press before a set state auto-commits (10 s at 2 ms per tick); must be >= 1.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- o_db_ena  out  1  one-cycle enable strobe to all debouncers, once every TICK_DIV clocks.
- i_mode_pulse  in  1  debounced MODE press; held high for one full enable period.
- i_inc_pulse  in  1  debounced INC press, same format.
- i_dec_pulse  in  1  debounced DEC press, same format.
- i_hours  in  5  live hours from the timekeeper, 0..23.
- i_mins  in  6  live minutes, 0..59.
- i_secs  in  6  live seconds, 0..59.
- o_run  out  1  timekeeper count enable; 0 while editing.
- o_load  out  1  one-cycle strobe: timekeeper loads o_hours/o_mins/o_secs.
- o_hours  out  5  edit hours.
- o_mins  out  6  edit minutes.
- o_secs  out  6  edit seconds.
- o_field  out  2  field being edited: 0 none, 1 hours, 2 minutes, 3 seconds (used for display blink).

Behaviour:
- Reset values (synchronous, i_rst=1 at a rising edge):
  - state RUN, prescaler 0, inactivity counter 0.
  - o_db_ena=0, o_run=1, o_load=0, o_field=0.
  - o_hours=0, o_mins=0, o_secs=0.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps.
  - o_db_ena is registered and high exactly one cycle per wrap.
  - First strobe appears on the TICK_DIV-th cycle after i_rst deasserts; later strobes are spaced exactly TICK_DIV clocks apart.
- Pulse sampling:
  - i_*_pulse are sampled only in cycles where o_db_ena=1 (the tick). They are ignored in all other cycles.
  - Each press is therefore seen exactly once.
- States: RUN, SET_H, SET_M, SET_S. o_field is 0/1/2/3 respectively. o_run=1 only in RUN.
- RUN:
  - Tick with MODE: copy i_hours/i_mins/i_secs into the edit registers and go to SET_H.
  - INC and DEC are ignored in RUN.
- Mode advance:
  - SET_H + MODE -> SET_M.
  - SET_M + MODE -> SET_S.
  - SET_S + MODE -> RUN and commit.
- Commit:
  - o_load=1 for exactly the one cycle after the deciding tick.
  - In that same cycle o_run returns to 1 and o_field returns to 0.
  - Edit registers hold their values through and after the load.
- Edit field (active field only, on a tick):
  - INC: hours 23->0 wrap, else +1; minutes and seconds 59->0 wrap, else +1.
  - DEC: hours 0->23 wrap, else -1; minutes and seconds 0->59 wrap, else -1.
  - Updated value is visible the cycle after the tick.
- Simultaneous events on one tick:
  - MODE has priority: the field does not change, only the state advances.
  - INC and DEC together with no MODE: no change, but the tick still counts as activity.
- Inactivity timeout:
  - In a set state, a tick with any pulse clears the counter.
  - A tick with no pulse increments it.
  - On reaching AUTO_EXIT_TICKS, go to RUN with a commit identical to the SET_S+MODE path.
  - The counter is cleared on entry to SET_H and whenever in RUN.
- Reset mid-edit: the edit is abandoned, no o_load is issued, state goes to RUN.
- Pulses are assumed synchronous to i_clk; no further synchronisation is done in this block.

Test Plan:
- Simulation uses TICK_DIV=4 and AUTO_EXIT_TICKS=8.
1. Reset release -> o_db_ena high on cycles 4, 8, 12, ... (one cycle wide); o_run=1, o_load=0, o_field=0 throughout.
2. i_hours=13, i_mins=45, i_secs=30; MODE across one tick -> o_field=1, o_run=0, o_hours=13, o_mins=45, o_secs=30.
3. In SET_H at 23: one INC -> 0. In SET_M at 0: one DEC -> 59. MODE+INC on the same tick -> state advances, field value unchanged.
4. Edit to 07:05:59, then MODE from SET_S -> o_load exactly one cycle with 7/5/59; o_run=1 and o_field=0 in that same cycle.
5. Enter SET_M, then no presses for 8 ticks -> commit o_load on the cycle after the 8th tick; a press at tick 5 instead restarts the count.
6. i_rst asserted while in SET_S -> RUN, no o_load pulse ever, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debouncer enable prescaler, RUN/SET_H/SET_M/SET_S sequencing,
// edit registers and the single-cycle load strobe towards the timekeeper.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV        = 200000,
  parameter int unsigned AUTO_EXIT_TICKS = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_db_ena,
  input  logic       i_mode_pulse,
  input  logic       i_inc_pulse,
  input  logic       i_dec_pulse,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_mins,
  input  logic [5:0] i_secs,
  output logic       o_run,
  output logic       o_load,
  output logic [4:0] o_hours,
  output logic [5:0] o_mins,
  output logic [5:0] o_secs,
  output logic [1:0] o_field
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IdleW  = $clog2(AUTO_EXIT_TICKS + 1);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [IdleW-1:0]  IdleLast = IdleW'(AUTO_EXIT_TICKS - 1);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StSetH = 2'd1,
    StSetM = 2'd2,
    StSetS = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic              ena_q, ena_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              load_q, load_d;
  logic [4:0]        hours_q, hours_d;
  logic [5:0]        mins_q, mins_d;
  logic [5:0]        secs_q, secs_d;

  logic tick, any_press, step_up, step_dn;

  // One modular step on a field whose legal range is 0..max.
  function automatic logic [5:0] wrap_step(logic [5:0] value, logic [5:0] max, logic up);
    logic [5:0] res;
    if (up) begin
      res = (value == max) ? 6'd0 : value + 6'd1;
    end else begin
      res = (value == 6'd0) ? max : value - 6'd1;
    end
    return res;
  endfunction

  // Pulses only matter on the enable tick, so each debounced press is seen once.
  assign tick      = ena_q;
  assign any_press = i_mode_pulse | i_inc_pulse | i_dec_pulse;
  assign step_up   = i_inc_pulse & ~i_dec_pulse;
  assign step_dn   = i_dec_pulse & ~i_inc_pulse;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q + PrescW'(1);
    ena_d   = 1'b0;
    idle_d  = idle_q;
    load_d  = 1'b0;
    hours_d = hours_q;
    mins_d  = mins_q;
    secs_d  = secs_q;

    if (presc_q == PrescMax) begin
      presc_d = '0;
      ena_d   = 1'b1;
    end

    unique case (state_q)
      StRun: begin
        idle_d = '0;
        if (tick && i_mode_pulse) begin
          hours_d = i_hours;
          mins_d  = i_mins;
          secs_d  = i_secs;
          state_d = StSetH;
        end
      end
      default: begin
        if (tick) begin
          if (any_press) begin
            idle_d = '0;
          end else if (idle_q == IdleLast) begin
            idle_d  = '0;
            state_d = StRun;
            load_d  = 1'b1;
          end else begin
            idle_d = idle_q + IdleW'(1);
          end

          if (i_mode_pulse) begin
            unique case (state_q)
              StSetH:  state_d = StSetM;
              StSetM:  state_d = StSetS;
              default: begin
                state_d = StRun;
                load_d  = 1'b1;
              end
            endcase
          end else if (step_up || step_dn) begin
            unique case (state_q)
              StSetH:  hours_d = 5'(wrap_step({1'b0, hours_q}, 6'd23, step_up));
              StSetM:  mins_d  = wrap_step(mins_q, 6'd59, step_up);
              default: secs_d  = wrap_step(secs_q, 6'd59, step_up);
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StRun;
      presc_q <= '0;
      ena_q   <= 1'b0;
      idle_q  <= '0;
      load_q  <= 1'b0;
      hours_q <= '0;
      mins_q  <= '0;
      secs_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ena_q   <= ena_d;
      idle_q  <= idle_d;
      load_q  <= load_d;
      hours_q <= hours_d;
      mins_q  <= mins_d;
      secs_q  <= secs_d;
    end
  end

  assign o_db_ena = ena_q;
  assign o_run    = (state_q == StRun);
  assign o_load   = load_q;
  assign o_field  = state_q;
  assign o_hours  = hours_q;
  assign o_mins   = mins_q;
  assign o_secs   = secs_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed opening sequence, then random presses with quiet stretches
// and occasional mid-edit resets, checked every cycle against a field-level reference model.
module tb_clock_set_ctrl;

  localparam int unsigned TickDiv  = 4;
  localparam int unsigned AutoExit = 8;
  localparam int unsigned NCycles  = 6000;

  logic       clk = 1'b0;
  logic       rst;
  logic       db_ena;
  logic       mode_pulse, inc_pulse, dec_pulse;
  logic [4:0] hours_in;
  logic [5:0] mins_in, secs_in;
  logic       run, load;
  logic [4:0] hours_out;
  logic [5:0] mins_out, secs_out;
  logic [1:0] field;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .TICK_DIV       (TickDiv),
    .AUTO_EXIT_TICKS(AutoExit)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_db_ena    (db_ena),
    .i_mode_pulse(mode_pulse),
    .i_inc_pulse (inc_pulse),
    .i_dec_pulse (dec_pulse),
    .i_hours     (hours_in),
    .i_mins      (mins_in),
    .i_secs      (secs_in),
    .o_run       (run),
    .o_load      (load),
    .o_hours     (hours_out),
    .o_mins      (mins_out),
    .o_secs      (secs_out),
    .o_field     (field)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: cycle index since reset plus the clock-setting state in plain numbers.
  int unsigned n;
  int unsigned m_field, m_h, m_m, m_s, m_idle;
  int unsigned m_load;
  int unsigned quiet_left, resets_done;

  typedef struct {
    int unsigned mode;
    int unsigned inc;
    int unsigned dec;
    int unsigned h;
    int unsigned m;
    int unsigned s;
  } stim_t;

  stim_t dir_q[$];

  task automatic reset_model();
    n       = 0;
    m_field = 0;
    m_h     = 0;
    m_m     = 0;
    m_s     = 0;
    m_idle  = 0;
    m_load  = 0;
  endtask

  task automatic apply(input stim_t st);
    mode_pulse = st.mode[0];
    inc_pulse  = st.inc[0];
    dec_pulse  = st.dec[0];
    hours_in   = 5'(st.h);
    mins_in    = 6'(st.m);
    secs_in    = 6'(st.s);
  endtask

  task automatic pick_stimulus();
    stim_t st;
    if (dir_q.size() > 0) begin
      st = dir_q.pop_front();
    end else begin
      st.h = $urandom_range(0, 23);
      st.m = $urandom_range(0, 59);
      st.s = $urandom_range(0, 59);
      if (quiet_left > 0) begin
        quiet_left--;
        st.mode = 0;
        st.inc  = 0;
        st.dec  = 0;
      end else begin
        if ($urandom_range(0, 11) == 0) quiet_left = $urandom_range(4, 11);
        st.mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
        st.inc  = ($urandom_range(0, 2) == 0) ? 1 : 0;
        st.dec  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      end
    end
    apply(st);
  endtask

  function automatic int unsigned step(input int unsigned v, input int unsigned range,
                                       input bit up);
    return up ? (v + 1) % range : (v + range - 1) % range;
  endfunction

  // What the controller should do on one enable tick, expressed at field level.
  task automatic tick_model(output int unsigned load_next);
    bit up, dn;
    load_next = 0;
    up = inc_pulse && !dec_pulse;
    dn = dec_pulse && !inc_pulse;
    if (m_field == 0) begin
      m_idle = 0;
      if (mode_pulse) begin
        m_h     = hours_in;
        m_m     = mins_in;
        m_s     = secs_in;
        m_field = 1;
      end
    end else if (mode_pulse) begin
      m_idle = 0;
      if (m_field == 3) begin
        m_field   = 0;
        load_next = 1;
      end else begin
        m_field++;
      end
    end else if (inc_pulse || dec_pulse) begin
      m_idle = 0;
      if (up || dn) begin
        if (m_field == 1) m_h = step(m_h, 24, up);
        else if (m_field == 2) m_m = step(m_m, 60, up);
        else m_s = step(m_s, 60, up);
      end
    end else begin
      m_idle++;
      if (m_idle == AutoExit) begin
        m_idle    = 0;
        m_field   = 0;
        load_next = 1;
      end
    end
  endtask

  initial begin
    int unsigned load_next;
    stim_t idle_st;
    idle_st = '{0, 0, 0, 0, 0, 0};
    dir_q.push_back('{1, 0, 0, 13, 45, 30});
    dir_q.push_back('{1, 0, 0, 2, 3, 4});
    dir_q.push_back('{1, 0, 0, 2, 3, 4});
    dir_q.push_back('{1, 0, 0, 2, 3, 4});
    dir_q.push_back('{1, 0, 0, 23, 0, 59});
    dir_q.push_back('{0, 1, 0, 5, 5, 5});
    dir_q.push_back('{1, 0, 0, 5, 5, 5});
    dir_q.push_back('{0, 0, 1, 5, 5, 5});
    dir_q.push_back('{1, 1, 0, 5, 5, 5});
    dir_q.push_back('{0, 1, 0, 5, 5, 5});
    dir_q.push_back('{0, 1, 1, 5, 5, 5});
    quiet_left  = 0;
    resets_done = 0;

    rst = 1'b1;
    apply(idle_st);
    reset_model();
    repeat (2) @(negedge clk);

    for (int cyc = 0; cyc < NCycles; cyc++) begin
      check("db_ena", 32'(db_ena), (n > 0 && n % TickDiv == 0) ? 1 : 0);
      check("run", 32'(run), (m_field == 0) ? 1 : 0);
      check("load", 32'(load), m_load);
      check("field", 32'(field), m_field);
      check("hours", 32'(hours_out), m_h);
      check("mins", 32'(mins_out), m_m);
      check("secs", 32'(secs_out), m_s);

      rst = 1'b0;
      if (n == 0) apply(idle_st);
      else if (n % TickDiv == 1) pick_stimulus();

      if (m_field == 3 && n > 0 && resets_done < 6 && $urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        resets_done++;
        reset_model();
      end else begin
        load_next = 0;
        if (n > 0 && n % TickDiv == 0) tick_model(load_next);
        m_load = load_next;
        n++;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
